// File: rtl/charge_scanner.sv
// charge_scanner: walks the accumulator read port at the end of each time
// reference, compares every signed 8-bit charge against a latched threshold
// and streams one spike event per firing neuron, in ascending neuron order.
//
// state | meaning
// IDLE  | waiting for start_i; busy_o low
// FETCH | word count_o on charge_i; build firing mask for that word
// EMIT  | present firing lanes of the word one at a time over valid/ready
// DONE  | one-cycle done_o pulse; then back to IDLE with count_o cleared
module charge_scanner #(
  parameter  int N  = 256,
  localparam int W  = $clog2(N/4),
  localparam int AW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start_i,
  input  logic [7:0]    threshold_i,
  input  logic [31:0]   charge_i,
  output logic [W-1:0]  count_o,
  output logic          spike_valid_o,
  input  logic          spike_ready_i,
  output logic [AW-1:0] spike_addr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW:0]   spike_cnt_o
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  localparam logic [W-1:0] LAST_WORD = W'(N/4 - 1);

  state_t     state_q;
  logic [7:0] thr_q;
  logic [3:0] mask_q;
  logic [3:0] mask_c;
  logic [3:0] mask_rest;

  // index of the lowest set bit; lanes are emitted lowest first
  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  // per-lane signed compare of the current word against the threshold,
  // and the mask left after the lane on display is accepted
  always_comb begin
    mask_c = '0;
    for (int k = 0; k < 4; k++) begin
      mask_c[k] = $signed(charge_i[8*k +: 8]) >= $signed(thr_q);
    end
    mask_rest = mask_q & (mask_q - 4'd1);
  end

  // scan sequencer with registered outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q       <= IDLE;
      thr_q         <= '0;
      mask_q        <= '0;
      count_o       <= '0;
      spike_valid_o <= 1'b0;
      spike_addr_o  <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      spike_cnt_o   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            thr_q       <= threshold_i;
            count_o     <= '0;
            spike_cnt_o <= '0;
            busy_o      <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          mask_q <= mask_c;
          if (mask_c != 4'd0) begin
            spike_valid_o <= 1'b1;
            spike_addr_o  <= {count_o, low_idx(mask_c)};
            state_q       <= EMIT;
          end else if (count_o == LAST_WORD) begin
            done_o  <= 1'b1;
            state_q <= DONE;
          end else begin
            count_o <= count_o + 1'b1;
          end
        end
        EMIT: begin
          if (spike_ready_i) begin
            mask_q      <= mask_rest;
            spike_cnt_o <= spike_cnt_o + 1'b1;
            if (mask_rest != 4'd0) begin
              spike_addr_o <= {count_o, low_idx(mask_rest)};
            end else begin
              spike_valid_o <= 1'b0;
              if (count_o == LAST_WORD) begin
                done_o  <= 1'b1;
                state_q <= DONE;
              end else begin
                count_o <= count_o + 1'b1;
                state_q <= FETCH;
              end
            end
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          count_o <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_charge_scanner.sv
// tb_charge_scanner: randomized and directed scans against a reference that
// lists the expected spike addresses straight from the charge memory.
module tb_charge_scanner;

  localparam int N  = 256;
  localparam int NW = N / 4;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  threshold_i = '0;
  logic [31:0] charge_i;
  logic [5:0]  count_o;
  logic        spike_valid_o;
  logic        spike_ready_i = 1'b0;
  logic [7:0]  spike_addr_o;
  logic        busy_o;
  logic        done_o;
  logic [8:0]  spike_cnt_o;

  logic [31:0] mem [NW];

  int checks   = 0;
  int failures = 0;

  assign charge_i = mem[count_o];

  charge_scanner #(.N(N)) dut (
    .CLK(CLK), .RSTN(RSTN), .start_i(start_i), .threshold_i(threshold_i),
    .charge_i(charge_i), .count_o(count_o), .spike_valid_o(spike_valid_o),
    .spike_ready_i(spike_ready_i), .spike_addr_o(spike_addr_o),
    .busy_o(busy_o), .done_o(done_o), .spike_cnt_o(spike_cnt_o)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_zero();
    for (int w = 0; w < NW; w++) mem[w] = '0;
  endtask

  task automatic fill_random();
    for (int w = 0; w < NW; w++) mem[w] = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_count"}, count_o, 0);
    check_eq({tag, "_valid"}, spike_valid_o, 0);
    check_eq({tag, "_addr"}, spike_addr_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
    check_eq({tag, "_cnt"}, spike_cnt_o, 0);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low for 7 cycles at first spike
  task automatic run_scan(input logic [7:0] thr, input int rmode, input bit mid_start);
    int q[$];
    int nspk, stalls, cyc, hold;
    bit done_seen, prev_stall;
    int prev_addr;
    q = {};
    for (int n = 0; n < N; n++) begin
      logic [31:0] word;
      logic [7:0]  lane;
      word = mem[n / 4];
      lane = word[8*(n % 4) +: 8];
      if ($signed(lane) >= $signed(thr)) q.push_back(n);
    end
    nspk = q.size();
    stalls = 0; hold = 0; done_seen = 0; prev_stall = 0; prev_addr = 0;
    @(negedge CLK);
    start_i = 1'b1; threshold_i = thr;
    @(negedge CLK);
    start_i = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 3000) begin
      if (mid_start && cyc == 10) begin
        start_i = 1'b1; threshold_i = 8'h80;
      end else begin
        start_i = 1'b0; threshold_i = thr + 8'd1;
      end
      case (rmode)
        0: spike_ready_i = 1'b1;
        1: spike_ready_i = 1'($urandom_range(0, 1));
        default: spike_ready_i = !(spike_valid_o && hold < 7);
      endcase
      if (nspk == 0 && cyc <= NW) check_eq("silent_count", count_o, cyc - 1);
      if (prev_stall) begin
        check_eq("valid_held", spike_valid_o, 1);
        check_eq("addr_held", spike_addr_o, prev_addr);
      end
      prev_stall = 0;
      if (spike_valid_o) begin
        check_eq("busy_emit", busy_o, 1);
        if (q.size() == 0) begin
          check_eq("extra_spike", spike_addr_o, -1);
        end else begin
          check_eq("spike_addr", spike_addr_o, q[0]);
          check_eq("count_emit", count_o, q[0] / 4);
          if (spike_ready_i) void'(q.pop_front());
        end
        if (!spike_ready_i) begin
          stalls++; hold++; prev_stall = 1; prev_addr = spike_addr_o;
        end
      end
      if (done_o) begin
        done_seen = 1;
        check_eq("done_cycle", cyc, NW + 1 + nspk + stalls);
        check_eq("spike_cnt", spike_cnt_o, nspk);
        check_eq("left_spikes", q.size(), 0);
        check_eq("busy_done", busy_o, 1);
      end
      @(negedge CLK);
      cyc++;
    end
    start_i = 1'b0;
    check_eq("done_seen", done_seen, 1);
    check_eq("busy_after", busy_o, 0);
    check_eq("done_after", done_o, 0);
    check_eq("count_after", count_o, 0);
    check_eq("cnt_held", spike_cnt_o, nspk);
    if (rmode == 2 && nspk > 0) check_eq("stall_cycles", stalls, 7);
  endtask

  initial begin
    fill_zero();
    repeat (2) @(negedge CLK);
    check_reset_outputs("reset");
    RSTN = 1'b1;
    @(negedge CLK);

    // silent scan
    run_scan(8'd1, 0, 0);

    // directed word 5: lanes {10,-3,4,4} with threshold 4
    mem[5] = {8'd10, 8'hFD, 8'd4, 8'd4};
    run_scan(8'd4, 0, 0);
    run_scan(8'd4, 2, 0);

    // every neuron fires at the minimum threshold
    fill_random();
    run_scan(8'h80, 1, 0);

    // extremes in word 0
    fill_zero();
    mem[0] = {8'd0, 8'd0, 8'd127, 8'h80};
    run_scan(8'd127, 0, 0);
    run_scan(8'h80, 1, 0);

    // random scans, one with a mid-scan start that must be ignored
    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_scan(8'($urandom_range(0, 255)), 1, i == 0);
    end

    // reset while a spike is pending, then a fresh scan
    fill_zero();
    mem[5] = {8'd10, 8'hFD, 8'd4, 8'd4};
    @(negedge CLK);
    start_i = 1'b1; threshold_i = 8'd4;
    @(negedge CLK);
    start_i = 1'b0; spike_ready_i = 1'b0;
    for (int c = 0; c < 20 && !spike_valid_o; c++) @(negedge CLK);
    check_eq("rst_pre_valid", spike_valid_o, 1);
    RSTN = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check_eq("midreset_nodone", done_o, 0);
    end
    RSTN = 1'b1;
    @(negedge CLK);
    check_reset_outputs("postreset");
    fill_random();
    run_scan(8'($urandom_range(0, 255)), 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
